chess_move_ctrl: RTL and testbench

CHESS_MOVE_CTRL -- requirements
Module: chess_move_ctrl

---
 rtl/chess_move_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_chess_move_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_move_ctrl.sv
// chess_move_ctrl: keyboard-driven select/place move controller for a 3x3 two-player board.
// Optional per-turn move timer is compiled in when MOVE_TIMEOUT_EN is defined.
module chess_move_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  ascii,
   input  logic        new_ascii,
   input  logic [4:0]  cursor,
   output logic [17:0] board,
   output logic        player,
   output logic        held,
   output logic [3:0]  sel_field,
   output logic        move_done,
   output logic [3:0]  from_field,
   output logic [3:0]  to_field,
   output logic        err,
   output logic        game_over,
   output logic        winner,
   output logic        timeout,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_SELECT = 2'd0,
      S_HELD   = 2'd1,
      S_COMMIT = 2'd2,
      S_OVER   = 2'd3
   } state_t;

   localparam logic [17:0] BOARD_INIT = 18'b01_01_01_00_00_00_10_10_10;
   localparam logic [7:0]  KEY_E      = 8'h45;
   localparam logic [7:0]  KEY_Q      = 8'h51;
   localparam logic [7:0]  KEY_R      = 8'h52;

   function automatic logic [1:0] get_field(input logic [17:0] b, input logic [3:0] idx);
      logic [1:0] code;
      code = 2'b00;
      for (int i = 1; i <= 9; i++)
         if (idx == 4'(i)) code = b[2*i-2 +: 2];
      return code;
   endfunction

   function automatic logic [17:0] set_field(input logic [17:0] b, input logic [3:0] idx,
                                             input logic [1:0] code);
      logic [17:0] r;
      r = b;
      for (int i = 1; i <= 9; i++)
         if (idx == 4'(i)) r[2*i-2 +: 2] = code;
      return r;
   endfunction

   function automatic logic [3:0] count_code(input logic [17:0] b, input logic [1:0] code);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 1; i <= 9; i++)
         if (b[2*i-2 +: 2] == code) n = n + 4'd1;
      return n;
   endfunction

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        player_q, player_d;
   logic        held_q, held_d;
   logic [3:0]  sel_q, sel_d;
   logic        move_done_q, move_done_d;
   logic [3:0]  from_q, from_d;
   logic [3:0]  to_q, to_d;
   logic        err_q, err_d;
   logic        game_over_q, game_over_d;
   logic        winner_q, winner_d;

   logic        key_e, key_q, key_r, restart, cur_ok;
   logic [1:0]  own_code, cur_code;
   logic [17:0] board_mv;

`ifdef MOVE_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      player_d    = player_q;
      held_d      = held_q;
      sel_d       = sel_q;
      move_done_d = 1'b0;
      from_d      = 4'd0;
      to_d        = 4'd0;
      err_d       = 1'b0;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      restart     = 1'b0;
      key_e       = new_ascii && (ascii == KEY_E);
      key_q       = new_ascii && (ascii == KEY_Q);
      key_r       = new_ascii && (ascii == KEY_R);
      own_code    = player_q ? 2'b10 : 2'b01;
      cur_ok      = (cursor >= 5'd1) && (cursor <= 5'd9);
      cur_code    = get_field(board_q, cursor[3:0]);
      // Board image as it will look once the pending move lands (used only in COMMIT).
      board_mv    = set_field(set_field(board_q, to_q, own_code), from_q, 2'b00);

      unique case (state_q)
         S_SELECT: begin
            if (key_r) restart = 1'b1;
            else if (key_e) begin
               if (cur_ok && cur_code == own_code) begin
                  sel_d   = cursor[3:0];
                  held_d  = 1'b1;
                  state_d = S_HELD;
               end else err_d = 1'b1;
            end
         end
         S_HELD: begin
            if (key_r) restart = 1'b1;
            else if (key_q) begin
               held_d  = 1'b0;
               sel_d   = 4'd0;
               state_d = S_SELECT;
            end else if (key_e) begin
               if (cur_ok && cursor[3:0] != sel_q && cur_code != own_code) begin
                  state_d     = S_COMMIT;
                  move_done_d = 1'b1;
                  from_d      = sel_q;
                  to_d        = cursor[3:0];
               end else err_d = 1'b1;
            end
         end
         S_COMMIT: begin
            board_d  = board_mv;
            player_d = ~player_q;
            held_d   = 1'b0;
            sel_d    = 4'd0;
            if (count_code(board_mv, ~own_code) == 4'd0) begin
               state_d     = S_OVER;
               game_over_d = 1'b1;
               winner_d    = player_q;
            end else state_d = S_SELECT;
         end
         S_OVER: begin
            if (key_r) restart = 1'b1;
         end
         default: state_d = S_SELECT;
      endcase

      if (restart) begin
         state_d     = S_SELECT;
         board_d     = BOARD_INIT;
         player_d    = 1'b0;
         held_d      = 1'b0;
         sel_d       = 4'd0;
         game_over_d = 1'b0;
         winner_d    = 1'b0;
      end

`ifdef MOVE_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = 1'b0;
      // Expiry forfeits the turn and overrides whatever key arrived this cycle.
      if ((state_q == S_SELECT || state_q == S_HELD) && cnt_q == CNT_LAST) begin
         state_d     = S_SELECT;
         board_d     = board_q;
         player_d    = ~player_q;
         held_d      = 1'b0;
         sel_d       = 4'd0;
         move_done_d = 1'b0;
         from_d      = 4'd0;
         to_d        = 4'd0;
         err_d       = 1'b0;
         game_over_d = game_over_q;
         winner_d    = winner_q;
         timeout_d   = 1'b1;
      end else if ((state_q == S_SELECT || state_q == S_HELD) &&
                   (state_d == S_SELECT || state_d == S_HELD) && !restart) begin
         cnt_d = cnt_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_SELECT;
         board_q     <= BOARD_INIT;
         player_q    <= 1'b0;
         held_q      <= 1'b0;
         sel_q       <= 4'd0;
         move_done_q <= 1'b0;
         from_q      <= 4'd0;
         to_q        <= 4'd0;
         err_q       <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         player_q    <= player_d;
         held_q      <= held_d;
         sel_q       <= sel_d;
         move_done_q <= move_done_d;
         from_q      <= from_d;
         to_q        <= to_d;
         err_q       <= err_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
`ifdef MOVE_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign board      = board_q;
   assign player     = player_q;
   assign held       = held_q;
   assign sel_field  = sel_q;
   assign move_done  = move_done_q;
   assign from_field = from_q;
   assign to_field   = to_q;
   assign err        = err_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign state_dbg  = state_q;
`ifdef MOVE_TIMEOUT_EN
   assign timeout    = timeout_q;
`else
   assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_chess_move_ctrl.sv
// tb_chess_move_ctrl: directed scenarios plus random key streams against a board-level model.
module tb_chess_move_ctrl;

`ifdef MOVE_TIMEOUT_EN
   localparam int unsigned T_CYC = 16;
`else
   localparam int unsigned T_CYC = 50000000;
`endif
   localparam logic [17:0] INIT_IMG = 18'b01_01_01_00_00_00_10_10_10;
   localparam logic [7:0]  K_E = 8'h45;
   localparam logic [7:0]  K_Q = 8'h51;
   localparam logic [7:0]  K_R = 8'h52;

   logic        CLK, RESET_N;
   logic [7:0]  ascii;
   logic        new_ascii;
   logic [4:0]  cursor;
   logic [17:0] board;
   logic        player, held, move_done, err, game_over, winner, timeout;
   logic [3:0]  sel_field, from_field, to_field;
   logic [1:0]  state_dbg;

   chess_move_ctrl #(.TIMEOUT_CYCLES(T_CYC)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ascii(ascii), .new_ascii(new_ascii), .cursor(cursor),
      .board(board), .player(player), .held(held), .sel_field(sel_field),
      .move_done(move_done), .from_field(from_field), .to_field(to_field), .err(err),
      .game_over(game_over), .winner(winner), .timeout(timeout), .state_dbg(state_dbg)
   );

   // Clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   int    n_cmp = 0;
   int    n_err = 0;
   string ph = "init";

   // Reference model: pieces per field (0 empty, 1 white, 2 black), turn and selection.
   int m_field[1:9];
   bit m_player, m_over, m_winner, m_commit;
   int m_sel, m_from, m_to, m_turn;
   bit e_err, e_done, e_tmo;
   int e_from, e_to;

   function automatic logic [17:0] board_img();
      logic [17:0] img;
      img = '0;
      for (int i = 1; i <= 9; i++) img[2*i-2 +: 2] = 2'(m_field[i]);
      return img;
   endfunction

   task automatic model_reset();
      for (int i = 1; i <= 9; i++) m_field[i] = (i <= 3) ? 2 : ((i >= 7) ? 1 : 0);
      m_player = 0; m_over = 0; m_winner = 0; m_commit = 0;
      m_sel = 0; m_from = 0; m_to = 0; m_turn = 0;
      e_err = 0; e_done = 0; e_tmo = 0; e_from = 0; e_to = 0;
   endtask

   task automatic model_step(input bit na, input logic [7:0] a, input int c);
      int own, opp, n;
      bit valid;
      e_err = 0; e_done = 0; e_tmo = 0; e_from = 0; e_to = 0;
      own = m_player ? 2 : 1;
      opp = 3 - own;
      if (m_commit) begin
         m_field[m_to] = own;
         m_field[m_from] = 0;
         n = 0;
         for (int i = 1; i <= 9; i++) if (m_field[i] == opp) n++;
         if (n == 0) begin
            m_over = 1;
            m_winner = (own == 2);
         end
         m_player = !m_player; m_sel = 0; m_commit = 0; m_turn = 0;
         return;
      end
`ifdef MOVE_TIMEOUT_EN
      if (!m_over && m_turn == int'(T_CYC) - 1) begin
         m_player = !m_player; m_sel = 0; m_turn = 0; e_tmo = 1;
         return;
      end
`endif
      if (na && a == K_R) begin
         for (int i = 1; i <= 9; i++) m_field[i] = (i <= 3) ? 2 : ((i >= 7) ? 1 : 0);
         m_player = 0; m_over = 0; m_winner = 0; m_sel = 0; m_turn = 0;
         return;
      end
      if (!m_over && na) begin
         valid = (c >= 1 && c <= 9);
         if (a == K_E) begin
            if (m_sel == 0) begin
               if (valid && m_field[c] == own) m_sel = c;
               else e_err = 1;
            end else begin
               if (valid && c != m_sel && m_field[c] != own) begin
                  m_commit = 1; m_from = m_sel; m_to = c;
                  e_done = 1; e_from = m_sel; e_to = c;
               end else e_err = 1;
            end
         end else if (a == K_Q && m_sel != 0) m_sel = 0;
      end
      if (m_over || m_commit) m_turn = 0;
      else m_turn++;
   endtask

   // Scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s: observed %0h expected %0h", ph, tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int exp_state;
      exp_state = m_over ? 3 : (m_commit ? 2 : (m_sel != 0 ? 1 : 0));
      check("board", board, board_img());
      check("player", player, m_player);
      check("held", held, m_sel != 0);
      check("sel_field", sel_field, m_sel);
      check("move_done", move_done, e_done);
      check("from_field", from_field, e_from);
      check("to_field", to_field, e_to);
      check("err", err, e_err);
      check("game_over", game_over, m_over);
      check("winner", winner, m_winner);
      check("timeout", timeout, e_tmo);
      check("state", state_dbg, exp_state);
   endtask

   // Drivers
   task automatic cycle(input bit na, input logic [7:0] a, input logic [4:0] c);
      new_ascii = na; ascii = a; cursor = c;
      @(posedge CLK); #1;
      model_step(na, a, int'(c));
      new_ascii = 1'b0;
      check_all();
   endtask

   task automatic press(input logic [7:0] a, input logic [4:0] c);
      cycle(1'b1, a, c);
   endtask

   task automatic move(input logic [4:0] src, input logic [4:0] dst);
      press(K_E, src);
      press(K_E, dst);
      cycle(1'b0, 8'h00, dst);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0; new_ascii = 1'b0;
      @(posedge CLK); #1;
      model_reset();
      check("rst_board", board, INIT_IMG);
      check("rst_player", player, 0);
      check("rst_held", held, 0);
      check("rst_sel", sel_field, 0);
      check("rst_pulses", {move_done, err, timeout, game_over, winner}, 0);
      check("rst_fromto", {from_field, to_field}, 0);
      check("rst_state", state_dbg, 0);
      RESET_N = 1'b1;
   endtask

   logic [17:0] saved;
   int          hit_at;
   int          r;
   logic [7:0]  k;

   initial begin
      RESET_N = 1'b0; new_ascii = 1'b0; ascii = 8'h00; cursor = 5'd0;
      model_reset();

      ph = "basic_move";
      do_reset();
      press(K_E, 5'd8);
      check("held8", held, 1);
      check("sel8", sel_field, 8);
      press(K_E, 5'd5);
      check("done", move_done, 1);
      check("from8", from_field, 8);
      check("to5", to_field, 5);
      cycle(1'b0, 8'h00, 5'd5);
      check("f8_empty", board[15:14], 2'b00);
      check("f5_white", board[9:8], 2'b01);
      check("player_black", player, 1);

      ph = "opp_select";
      do_reset();
      press(K_E, 5'd2);
      check("err_pulse", err, 1);
      check("state_select", state_dbg, 0);
      check("board_same", board, INIT_IMG);
      cycle(1'b0, 8'h00, 5'd2);
      check("err_single", err, 0);

      ph = "own_dest_cancel";
      do_reset();
      press(K_E, 5'd7);
      press(K_E, 5'd9);
      check("err_own", err, 1);
      check("still_held", held, 1);
      press(K_Q, 5'd9);
      check("q_held", held, 0);
      check("q_sel", sel_field, 0);
      check("q_err", err, 0);

      ph = "edge_cursor";
      do_reset();
      press(K_E, 5'd0);
      press(K_E, 5'd10);
      press(K_E, 5'd31);
      press(K_E, 5'd9);
      press(K_E, 5'd9);
      check("same_field_err", err, 1);
      press(8'h65, 5'd5);
      press(K_E, 5'd5);
      cycle(1'b0, 8'h00, 5'd5);

      ph = "capture_all";
      do_reset();
      move(5'd8, 5'd2);
      move(5'd1, 5'd4);
      move(5'd2, 5'd4);
      move(5'd3, 5'd6);
      move(5'd4, 5'd6);
      check("game_over", game_over, 1);
      check("winner_white", winner, 0);
      check("state_over", state_dbg, 3);
      saved = board;
      press(K_E, 5'd5);
      check("over_no_err", err, 0);
      check("over_board", board, saved);
      press(K_R, 5'd5);
      check("r_board", board, INIT_IMG);
      check("r_player", player, 0);
      check("r_over", game_over, 0);

      ph = "async_reset";
      do_reset();
      press(K_E, 5'd8);
      #2;
      RESET_N = 1'b0;
      #1;
      check("ar_held", held, 0);
      check("ar_sel", sel_field, 0);
      check("ar_board", board, INIT_IMG);
      check("ar_state", state_dbg, 0);
      do_reset();

      ph = "idle_held";
      do_reset();
      press(K_E, 5'd8);
      hit_at = 0;
      for (int i = 2; i <= 40 && hit_at == 0; i++) begin
         cycle(1'b0, 8'h00, 5'd3);
         if (timeout) hit_at = i;
      end
`ifdef MOVE_TIMEOUT_EN
      check("tmo_edge", hit_at, 16);
      check("tmo_player", player, 1);
      check("tmo_held", held, 0);
      check("tmo_board", board, INIT_IMG);
`else
      check("no_tmo", hit_at, 0);
      check("still_held_idle", held, 1);
`endif

      ph = "random";
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25) cycle(1'b0, 8'(K_E), 5'($urandom_range(0, 11)));
         else if (r < 75) press(K_E, 5'($urandom_range(0, 11)));
         else if (r < 88) press(K_Q, 5'($urandom_range(0, 11)));
         else if (r < 90) press(K_R, 5'($urandom_range(0, 11)));
         else begin
            k = 8'($urandom_range(0, 255));
            if (k == K_E || k == K_Q || k == K_R) k = 8'h41;
            press(k, 5'($urandom_range(0, 11)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
